cpu_obi_port_arbiter: RTL
=========================

# cpu_obi_port_arbiter

Two-to-one OBI arbiter that merges the CPU subsystem's instruction and data OBI master ports onto a single OBI master port toward the system bus. It is used on low-area configurations where the core shares one bus port. It arbitrates requests, holds a selection stable until it is granted, and tracks outstanding transactions in order. Each `rvalid`/`rdata` is returned to the requester that issued the transaction. It sits between `cpu_subsystem` and the system bus crossbar.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 2: maximum accepted-but-unanswered transactions on the bus port; range 1..8.
- `DATA_PRIORITY`, default 1: 1 = data port wins contested arbitration; 0 = round-robin between instr and data.

Ports:
- `clk_i`, input, 1: clock.
- `rst_ni`, input, 1: reset, asynchronous, active-low.
- `instr_req_i`, input, `obi_req_t`: core instruction request (req, we, be[3:0], addr[31:0], wdata[31:0]).
- `instr_resp_o`, output, `obi_resp_t`: instruction response (gnt, rvalid, rdata[31:0]).
- `data_req_i`, input, `obi_req_t`: core data request.
- `data_resp_o`, output, `obi_resp_t`: data response.
- `bus_req_o`, output, `obi_req_t`: merged request to the bus.
- `bus_resp_i`, input, `obi_resp_t`: bus response.
- `protocol_err_o`, output, 1: sticky; set when `bus_resp_i.rvalid` arrives with zero outstanding transactions.

## Operation
- State:
  - Route FIFO of `MAX_OUTSTANDING` 1-bit source IDs (0 = instr, 1 = data).
  - Outstanding count, width $clog2(MAX_OUTSTANDING+1).
  - Lock flag plus locked-source bit.
  - Round-robin pointer.
  - `protocol_err_o` flop.
- Accept event: `bus_req_o.req && bus_resp_i.gnt`. It pushes the selected source ID into the FIFO and increments the count.
- Response event: `bus_resp_i.rvalid`. It pops the FIFO head and decrements the count.
- Accept and response in the same cycle: count is unchanged, and FIFO push and pop both occur.
- Full (count == `MAX_OUTSTANDING`): `bus_req_o.req` = 0 and both gnts = 0, even if a response arrives in that cycle. There is no rvalid→req combinational path.
- Source selection when not full:
  - Lock set: select the locked source.
  - Only one requester active: select it.
  - Both active, `DATA_PRIORITY`=1: select data.
  - Both active, `DATA_PRIORITY`=0: select the source opposite to the round-robin pointer (the pointer stores the last accepted source).
- Lock: set when `bus_req_o.req`=1 and gnt=0, and captures the selected source; cleared on accept. This keeps `bus_req_o` stable until gnt, as OBI requires.
- The round-robin pointer updates to the accepted source on every accept.
- `bus_req_o` fields = fields of the selected source; `bus_req_o.req` = selected source's req (gated by not-full). All fields are 0 when nothing is selected.
- `instr_resp_o.gnt` = `bus_resp_i.gnt && bus_req_o.req && sel==instr`. `data_resp_o.gnt` is analogous.
- rvalid routing:
  - `instr_resp_o.rvalid` = `bus_resp_i.rvalid && count!=0 && head==0`.
  - `data_resp_o.rvalid` = `bus_resp_i.rvalid && count!=0 && head==1`.
  - `rdata` is forwarded to both ports unconditionally.
- rvalid with count==0: no pop, no count change, no rvalid forwarded, `protocol_err_o` set until reset.
- Requesters must hold req and payload until gnt. Dropping req while locked clears the lock next cycle without pushing anything.

## Timing
- Reset values:
  - FIFO empty, count 0, lock 0, round-robin pointer = data (so the first contested round-robin arbitration picks instr), `protocol_err_o` = 0.
  - All `bus_req_o` fields 0; all gnt/rvalid 0.
- Request path `*_req_i`→`bus_req_o` is combinational, adding zero cycles.
- gnt path `bus_resp_i.gnt`→`*_resp_o.gnt` is combinational.
- rvalid/rdata path is combinational; the FIFO head is registered.
- Back-to-back accepts are allowed every cycle while not full.
- A response may arrive in the cycle after accept at the earliest.
- Reset mid-operation discards all outstanding IDs. A later stray rvalid therefore sets `protocol_err_o`.

## Test plan
- Instr-only read, bus gnt same cycle, rvalid next cycle with rdata=0xDEADBEEF → instr gnt in cycle 0, instr rvalid in cycle 1 with 0xDEADBEEF, data rvalid stays 0, count returns to 0.
- Both requesting, `DATA_PRIORITY`=0, bus always grants, 4 cycles → accepted source order instr, data, instr, data; with `DATA_PRIORITY`=1 → data every cycle while data req is held.
- Instr selected, bus gnt withheld 3 cycles while data asserts req in cycle 1 → `bus_req_o` stays the instr addr for 4 cycles, then data is accepted in cycle 4.
- `MAX_OUTSTANDING`=2, two accepts with no rvalid → third request sees `bus_req_o.req`=0. rvalid in the same cycle still blocks; req is forwarded the next cycle.
- Interleaved instr, data, instr accepts, then 3 rvalids with rdata 1, 2, 3 → instr gets 1, data gets 2, instr gets 3.
- rvalid with count 0 → `protocol_err_o` rises the next cycle and stays high; `rst_ni` low clears it and empties the FIFO.

Source files
------------

// File: rtl/cpu_obi_port_arbiter.sv
// Two-to-one OBI arbiter merging instr/data ports onto one bus port; responses are routed back in order.
// Request/gnt/rvalid paths are combinational; selection is held stable until gnt and the bus port is
// blocked while MAX_OUTSTANDING transactions are pending.
// Packed layout: req vector = {req, we, be[3:0], addr[31:0], wdata[31:0]}, resp vector = {gnt, rvalid, rdata[31:0]}.
module cpu_obi_port_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned DATA_PRIORITY   = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [69:0] instr_req_i,
  output logic [33:0] instr_resp_o,
  input  logic [69:0] data_req_i,
  output logic [33:0] data_resp_o,
  output logic [69:0] bus_req_o,
  input  logic [33:0] bus_resp_i,
  output logic        protocol_err_o
);

  localparam int unsigned REQ_BIT    = 69;
  localparam int unsigned GNT_BIT    = 33;
  localparam int unsigned RVALID_BIT = 32;

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       lock_q, lock_d;
  logic                       lock_src_q, lock_src_d;
  logic                       rr_q, rr_d;
  logic                       perr_q, perr_d;

  logic full, sel, sel_vld, instr_act, data_act;
  logic bus_req, bus_gnt, bus_rvalid, accept, rsp_ok, head;

  assign instr_act  = instr_req_i[REQ_BIT];
  assign data_act   = data_req_i[REQ_BIT];
  assign bus_gnt    = bus_resp_i[GNT_BIT];
  assign bus_rvalid = bus_resp_i[RVALID_BIT];
  assign full       = (cnt_q == FULL_CNT);

  // Source select: 0 = instr, 1 = data. A locked source wins even if it has dropped req.
  always_comb begin
    sel     = 1'b0;
    sel_vld = 1'b0;
    if (!full) begin
      if (lock_q) begin
        sel     = lock_src_q;
        sel_vld = 1'b1;
      end else if (instr_act && data_act) begin
        sel     = (DATA_PRIORITY != 0) ? 1'b1 : ~rr_q;
        sel_vld = 1'b1;
      end else if (data_act) begin
        sel     = 1'b1;
        sel_vld = 1'b1;
      end else if (instr_act) begin
        sel     = 1'b0;
        sel_vld = 1'b1;
      end
    end
  end

  assign bus_req_o = sel_vld ? (sel ? data_req_i : instr_req_i) : '0;
  assign bus_req   = bus_req_o[REQ_BIT];
  assign accept    = bus_req && bus_gnt;
  assign rsp_ok    = bus_rvalid && (cnt_q != '0);
  assign head      = fifo_q[rd_ptr_q];

  assign instr_resp_o = {accept && !sel, rsp_ok && !head, bus_resp_i[31:0]};
  assign data_resp_o  = {accept && sel,  rsp_ok && head,  bus_resp_i[31:0]};
  assign protocol_err_o = perr_q;

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (accept) begin
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_ONE;
    end
    if (rsp_ok) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_ONE;
    end
    case ({accept, rsp_ok})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    // A stalled request pins the selection; a granted or withdrawn one releases it.
    lock_d     = bus_req && !bus_gnt;
    lock_src_d = sel;
    rr_d       = accept ? sel : rr_q;
    perr_d     = perr_q | (bus_rvalid && (cnt_q == '0));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      lock_src_q <= 1'b0;
      rr_q       <= 1'b1;
      perr_q     <= 1'b0;
    end else begin
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      rr_q       <= rr_d;
      perr_q     <= perr_d;
    end
  end

endmodule
